pzbcm_sram_arbiter: RTL and testbench
=====================================

// Module: pzbcm_sram_arbiter
// PURPOSE
//  Shares one single-port SRAM macro (pzbcm_sram, single_port_ram=1) among REQUESTERS clients.
//  Per-client valid/ready command channels; round-robin grant; one SRAM access per cycle.
//  Read data is returned to the issuing client via a tag pipeline matched to READ_LATENCY.
//  Sits between client engines and the SRAM wrapper; the SRAM sees a registered command bus.
// PARAMETERS
//  REQUESTERS     2     number of clients, >=2
//  WORDS          1024  SRAM depth
//  DATA_WIDTH     32    SRAM data width
//  READ_LATENCY   1     SRAM read latency in cycles from registered command, >=1
//  ADDRESS_WIDTH  pzbcm_sram_pkg::calc_pointer_width(WORDS)  (localparam)
// PORTS
//  i_clk              in   1                         clock
//  i_rst_n            in   1                         async active-low reset
//  i_request_valid    in   REQUESTERS                per-client command valid
//  o_request_ready    out  REQUESTERS                per-client command accept
//  i_request_write    in   REQUESTERS                1=write, 0=read
//  i_request_address  in   REQUESTERS x ADDRESS_WIDTH  per-client address
//  i_request_data     in   REQUESTERS x DATA_WIDTH   per-client write data
//  o_response_valid   out  REQUESTERS                read data valid, one-hot
//  o_response_data    out  DATA_WIDTH                read data, shared by all clients
//  o_sram_enable      out  1                         SRAM access strobe
//  o_sram_write       out  1                         SRAM write enable
//  o_sram_address     out  ADDRESS_WIDTH             SRAM address
//  o_sram_write_data  out  DATA_WIDTH                SRAM write data
//  i_sram_read_data   in   DATA_WIDTH                SRAM read data
//  i_lock             in   REQUESTERS                only with PZBCM_SRAM_ARBITER_LOCK_EN
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): o_sram_* = 0, o_response_valid = 0, tag pipeline cleared,
//    priority pointer = 0, lock state cleared. In-flight reads are dropped, never delivered.
//  - Grant (comb.): first client with valid=1 searching from pointer upward, mod REQUESTERS.
//    o_request_ready is one-hot at the granted client, 0 elsewhere, and all-zero if no valid.
//    Ready depends on valid (comb.); clients must not make valid depend on ready.
//  - Accept = valid & ready. On accept: pointer <= grant+1 mod REQUESTERS; the next cycle
//    o_sram_enable=1, o_sram_write/address/write_data = the accepted client's fields.
//    No accept: o_sram_enable=0; other o_sram_* hold their previous values.
//  - Throughput: one accept per cycle; back-to-back accepts from different clients allowed.
//  - Read tag: on a read accept, {valid, client index} enters a shift pipeline of depth
//    READ_LATENCY+1. o_response_valid[idx] pulses exactly READ_LATENCY+1 cycles after accept.
//    o_response_data = i_sram_read_data in that cycle. Writes produce no response.
//  - No response backpressure: clients must take response data in the valid cycle.
//  - Pointer wraps REQUESTERS-1 -> 0. A single persistent requester is granted every cycle.
//  - Held requests (valid=1, ready=0) may change fields; only fields at accept are used.
// CONFIGURATION
//  PZBCM_SRAM_ARBITER_LOCK_EN defined: i_lock port exists. An accept with i_lock[g]=1 locks
//    the grant to client g. While locked, only g may be granted and the pointer is frozen.
//    Lock releases on g's next accept with i_lock[g]=0; the pointer then becomes g+1.
//    Locked client idle (valid=0): nothing is granted, and the lock persists.
//  Not defined: no i_lock port; pure round-robin as above.
// TESTING
//  1 Reset: hold i_rst_n=0 with all valids=1 -> all ready=0, o_sram_enable=0, resp_valid=0.
//  2 REQUESTERS=2, both read every cycle, addr0=5, addr1=9 -> grants alternate 0,1,0,1.
//    o_sram_address sequence 5,9,5,9; resp_valid one-hot alternates at READ_LATENCY+1.
//  3 Client1 writes 0xDEADBEEF @3, then client0 reads @3 -> client0 resp data=0xDEADBEEF.
//    Check with READ_LATENCY=1 and 3.
//  4 Pointer wrap, REQUESTERS=3, only client2 valid, then all valid -> order 2,0,1,2.
//  5 Reset asserted while 2 reads in flight -> no resp_valid after reset release.
//    Next accept is granted to client 0.
//  6 LOCK_EN: client0 issues 4 beats, lock=1,1,1,0, client1 always valid -> client1 first
//    granted on the cycle after the 4th beat.

Source files
------------

// File: rtl/pzbcm_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among REQUESTERS clients, with read tag return.
// Optional grant locking is enabled by defining PZBCM_SRAM_ARBITER_LOCK_EN.
module pzbcm_sram_arbiter #(
  parameter int unsigned  REQUESTERS    = 2,
  parameter int unsigned  WORDS         = 1024,
  parameter int unsigned  DATA_WIDTH    = 32,
  parameter int unsigned  READ_LATENCY  = 1,
  localparam int unsigned ADDRESS_WIDTH = (WORDS >= 2) ? $clog2(WORDS) : 1
)(
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic [REQUESTERS-1:0]                    i_request_valid,
  output logic [REQUESTERS-1:0]                    o_request_ready,
  input  logic [REQUESTERS-1:0]                    i_request_write,
  input  logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0] i_request_address,
  input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]    i_request_data,
  output logic [REQUESTERS-1:0]                    o_response_valid,
  output logic [DATA_WIDTH-1:0]                    o_response_data,
  output logic                                     o_sram_enable,
  output logic                                     o_sram_write,
  output logic [ADDRESS_WIDTH-1:0]                 o_sram_address,
  output logic [DATA_WIDTH-1:0]                    o_sram_write_data,
  input  logic [DATA_WIDTH-1:0]                    i_sram_read_data
`ifdef PZBCM_SRAM_ARBITER_LOCK_EN
  ,
  input  logic [REQUESTERS-1:0]                    i_lock
`endif
);
  localparam int unsigned INDEX_WIDTH = $clog2(REQUESTERS);

  typedef logic [INDEX_WIDTH-1:0] index_t;

  function automatic index_t wrap_index(int unsigned value);
    return index_t'(value % REQUESTERS);
  endfunction

  function automatic logic [REQUESTERS-1:0] one_hot(index_t index);
    return REQUESTERS'(1) << index;
  endfunction

  index_t                  pointer;
  logic [REQUESTERS-1:0]   eligible;
  logic                    grant_found;
  index_t                  grant_index;
  index_t                  candidate;
  logic                    accept_write;
  logic [READ_LATENCY:0]   tag_valid;
  index_t                  tag_index [READ_LATENCY+1];

`ifdef PZBCM_SRAM_ARBITER_LOCK_EN
  logic                    locked;
  index_t                  lock_index;
`endif

  // Reset gates eligibility so no client sees ready while the arbiter is held in reset.
  always_comb begin
    eligible = i_request_valid & {REQUESTERS{i_rst_n}};
`ifdef PZBCM_SRAM_ARBITER_LOCK_EN
    if (locked) begin
      eligible = eligible & one_hot(lock_index);
    end
`endif
  end

  always_comb begin
    grant_found = 1'b0;
    grant_index = '0;
    candidate   = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      candidate = wrap_index(32'(pointer) + i);
      if (!grant_found && eligible[candidate]) begin
        grant_found = 1'b1;
        grant_index = candidate;
      end
    end
  end

  assign o_request_ready = grant_found ? one_hot(grant_index) : '0;
  assign accept_write    = i_request_write[grant_index];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pointer           <= '0;
      o_sram_enable     <= 1'b0;
      o_sram_write      <= 1'b0;
      o_sram_address    <= '0;
      o_sram_write_data <= '0;
    end else begin
      o_sram_enable <= grant_found;
      if (grant_found) begin
        pointer           <= wrap_index(32'(grant_index) + 1);
        o_sram_write      <= accept_write;
        o_sram_address    <= i_request_address[grant_index];
        o_sram_write_data <= i_request_data[grant_index];
      end
    end
  end

`ifdef PZBCM_SRAM_ARBITER_LOCK_EN
  // While locked the only grantable client is lock_index, so the pointer stays at lock_index+1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      locked     <= 1'b0;
      lock_index <= '0;
    end else if (grant_found) begin
      locked     <= i_lock[grant_index];
      lock_index <= grant_index;
    end
  end
`endif

  // Stage 0 lines up with the registered SRAM command; stage READ_LATENCY with its read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_valid <= '0;
      for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
        tag_index[i] <= '0;
      end
    end else begin
      tag_valid[0] <= grant_found && !accept_write;
      tag_index[0] <= grant_index;
      for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_index[i] <= tag_index[i-1];
      end
    end
  end

  assign o_response_valid = tag_valid[READ_LATENCY] ? one_hot(tag_index[READ_LATENCY]) : '0;
  assign o_response_data  = i_sram_read_data;

endmodule

// File: tb/tb_pzbcm_sram_arbiter.sv
// Randomized bench for pzbcm_sram_arbiter against a cycle-indexed reference model and SRAM model.
module tb_pzbcm_sram_arbiter;
  localparam int R  = 3;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int L  = 3;
`ifdef PZBCM_SRAM_ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [R-1:0]           valid = '0;
  logic [R-1:0]           ready;
  logic [R-1:0]           write = '0;
  logic [R-1:0][AW-1:0]   address = '0;
  logic [R-1:0][DW-1:0]   wdata = '0;
  logic [R-1:0]           lock = '0;
  logic [R-1:0]           resp_valid;
  logic [DW-1:0]          resp_data;
  logic                   sram_en;
  logic                   sram_wr;
  logic [AW-1:0]          sram_addr;
  logic [DW-1:0]          sram_wdata;
  logic [DW-1:0]          sram_rdata;
  logic                   sram_clear = 1'b1;

  always #5 clk = ~clk;

  pzbcm_sram_arbiter #(
    .REQUESTERS   (R),
    .WORDS        (64),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (L)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_request_valid   (valid),
    .o_request_ready   (ready),
    .i_request_write   (write),
    .i_request_address (address),
    .i_request_data    (wdata),
    .o_response_valid  (resp_valid),
    .o_response_data   (resp_data),
    .o_sram_enable     (sram_en),
    .o_sram_write      (sram_wr),
    .o_sram_address    (sram_addr),
    .o_sram_write_data (sram_wdata),
    .i_sram_read_data  (sram_rdata)
`ifdef PZBCM_SRAM_ARBITER_LOCK_EN
    ,
    .i_lock            (lock)
`endif
  );

  // SRAM macro: read data appears L cycles after the registered command; garbage otherwise.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_pipe [L];
  always @(posedge clk) begin
    if (sram_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (sram_en && sram_wr) begin
      mem[sram_addr] <= sram_wdata;
    end
    rd_pipe[0] <= (sram_en && !sram_wr) ? mem[sram_addr] : $urandom();
    for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign sram_rdata = rd_pipe[L-1];

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] data;
  } resp_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [DW-1:0] mm [64];
  int            ptr      = 0;
  bit            locked   = 1'b0;
  int            lock_idx = 0;
  logic          exp_en = 1'b0, exp_wr = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  resp_t         resp_q[$];
  int            dut_grants[$];
  logic [DW-1:0] resp0_last = '0;
  int            resp_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic rst_v, input logic [R-1:0] v, input logic [R-1:0] w,
                      input logic [R-1:0][AW-1:0] a, input logic [R-1:0][DW-1:0] d,
                      input logic [R-1:0] lk);
    logic [R-1:0] exp_rv;
    logic [R-1:0] exp_ready;
    logic [R-1:0] lk_eff;
    bit           found;
    int           g;
    @(posedge clk);
    #1;
    cyc++;
    check("sram_enable", sram_en, exp_en);
    check("sram_write", sram_wr, exp_wr);
    check("sram_address", sram_addr, exp_addr);
    check("sram_write_data", sram_wdata, exp_wdata);
    exp_rv = '0;
    if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
      exp_rv = R'(1) << resp_q[0].idx;
      check("response_data", resp_data, resp_q[0].data);
      void'(resp_q.pop_front());
    end
    check("response_valid", resp_valid, exp_rv);
    if (resp_valid != '0) resp_seen++;
    if (resp_valid[0]) resp0_last = resp_data;

    rst_n   = rst_v;
    valid   = v;
    write   = w;
    address = a;
    wdata   = d;
    lock    = lk;
    lk_eff  = LOCK_EN ? lk : '0;
    #1;

    found = 1'b0;
    g     = 0;
    for (int k = 0; k < R; k++) begin
      int c;
      c = (ptr + k) % R;
      if (!found && rst_v && v[c] && (!locked || c == lock_idx)) begin
        found = 1'b1;
        g     = c;
      end
    end
    exp_ready = found ? (R'(1) << g) : '0;
    check("request_ready", ready, exp_ready);
    for (int k = 0; k < R; k++) if (ready[k]) dut_grants.push_back(k);

    if (!rst_v) begin
      ptr = 0; locked = 1'b0; lock_idx = 0;
      resp_q.delete();
      exp_en = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
    end else if (found) begin
      exp_en    = 1'b1;
      exp_wr    = w[g];
      exp_addr  = a[g];
      exp_wdata = d[g];
      if (w[g]) mm[a[g]] = d[g];
      else resp_q.push_back('{cyc: cyc + L + 1, idx: g, data: mm[a[g]]});
      ptr      = (g + 1) % R;
      locked   = lk_eff[g];
      lock_idx = g;
    end else begin
      exp_en = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mm[i] = '0;
    #1 rst_n = 1'b0;

    // Reset held with every client requesting
    for (int i = 0; i < 3; i++) step(1'b0, 3'b111, '0, '0, '0, '0);
    check("reset_ready", ready, '0);
    check("reset_enable", sram_en, 1'b0);
    sram_clear = 1'b0;

    // Two clients reading 5 and 9 every cycle alternate starting at client 0
    dut_grants.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 3'b011, '0, {6'd0, 6'd9, 6'd5}, '0, '0);
    check("alt_g0", dut_grants[0], 0);
    check("alt_g1", dut_grants[1], 1);
    check("alt_g2", dut_grants[2], 0);
    check("alt_g3", dut_grants[3], 1);
    idle(L + 2);

    // Write then read back through a different client
    step(1'b1, 3'b010, 3'b010, {6'd0, 6'd3, 6'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, '0);
    step(1'b1, 3'b001, 3'b000, {6'd0, 6'd0, 6'd3}, '0, '0);
    idle(L + 2);
    check("raw_data", resp0_last, 32'hDEADBEEF);

    // Pointer wrap: lone client 2 then everyone
    dut_grants.delete();
    step(1'b1, 3'b100, '0, {6'd1, 6'd2, 6'd3}, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b111, '0, {6'd1, 6'd2, 6'd3}, '0, '0);
    check("wrap_g0", dut_grants[0], 2);
    check("wrap_g1", dut_grants[1], 0);
    check("wrap_g2", dut_grants[2], 1);
    check("wrap_g3", dut_grants[3], 2);
    idle(L + 2);

    // Reset while two reads are in flight
    step(1'b1, 3'b011, '0, {6'd0, 6'd9, 6'd5}, '0, '0);
    step(1'b1, 3'b011, '0, {6'd0, 6'd9, 6'd5}, '0, '0);
    step(1'b0, '0, '0, '0, '0, '0);
    step(1'b0, '0, '0, '0, '0, '0);
    resp_seen = 0;
    idle(L + 3);
    check("no_resp_after_reset", resp_seen, 0);
    dut_grants.delete();
    step(1'b1, 3'b111, '0, {6'd4, 6'd4, 6'd4}, '0, '0);
    check("post_reset_grant", dut_grants[0], 0);
    idle(L + 2);

`ifdef PZBCM_SRAM_ARBITER_LOCK_EN
    // Client 0 burst of four locked beats ahead of a persistent client 1
    dut_grants.delete();
    step(1'b1, 3'b001, '0, {6'd0, 6'd7, 6'd6}, '0, 3'b001);
    step(1'b1, 3'b011, '0, {6'd0, 6'd7, 6'd6}, '0, 3'b001);
    step(1'b1, 3'b011, '0, {6'd0, 6'd7, 6'd6}, '0, 3'b001);
    step(1'b1, 3'b011, '0, {6'd0, 6'd7, 6'd6}, '0, 3'b000);
    step(1'b1, 3'b010, '0, {6'd0, 6'd7, 6'd6}, '0, 3'b000);
    check("lock_b1", dut_grants[1], 0);
    check("lock_b3", dut_grants[3], 0);
    check("lock_release", dut_grants[4], 1);
    idle(L + 2);
`endif

    // Random traffic on a small address window to force read-after-write hits
    for (int i = 0; i < 400; i++) begin
      logic [R-1:0]         v, w, lk;
      logic [R-1:0][AW-1:0] a;
      logic [R-1:0][DW-1:0] d;
      v  = R'($urandom_range(0, 7));
      w  = R'($urandom());
      lk = ($urandom_range(0, 3) == 0) ? R'($urandom()) : '0;
      for (int k = 0; k < R; k++) begin
        a[k] = AW'($urandom_range(0, 7));
        d[k] = $urandom();
      end
      step(1'b1, v, w, a, d, lk);
    end
    idle(L + 3);
    check("drained", resp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
